alu_sequencer: RTL and testbench

Register-file front end that feeds the 3-bit combinational ALU. It accepts one instruction at a time over a valid/ready handshake and reads two operands from an 8×3-bit register file, or takes one operand as an immediate. It drives the ALU, writes the result back to the destination register, and presents the result downstream over a second valid/ready handshake. It is the stage directly upstream of the ALU and owns its operand sourcing.

---
 rtl/alu_pkg.sv | 71 +++++++
 rtl/alu_regfile.sv | 41 ++++
 rtl/alu_sequencer.sv | 98 +++++++++
 tb/tb_alu_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, instruction layout, FSM states
// and the reference opcode semantics of the 3-bit ALU.
package alu_pkg;

  localparam int DATA_W  = 3;
  localparam int INSTR_W = 13;

  localparam int IMM_BIT = 12;
  localparam int OP_MSB  = 11;
  localparam int OP_LSB  = 9;
  localparam int RD_MSB  = 8;
  localparam int RD_LSB  = 6;
  localparam int RA_MSB  = 5;
  localparam int RA_LSB  = 3;
  localparam int RB_MSB  = 2;
  localparam int RB_LSB  = 0;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic              imm;
    op_e               op;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
  } instr_t;

  function automatic instr_t decode_instr(logic [INSTR_W-1:0] w);
    instr_t d;
    d.imm = w[IMM_BIT];
    d.op  = op_e'(w[OP_MSB:OP_LSB]);
    d.rd  = w[RD_MSB:RD_LSB];
    d.ra  = w[RA_MSB:RA_LSB];
    d.rb  = w[RB_MSB:RB_LSB];
    return d;
  endfunction

  // All arithmetic wraps at 3 bits; shifts by 3 or more clear the operand.
  function automatic logic [DATA_W-1:0] alu_compute(op_e op, logic [DATA_W-1:0] x,
                                                    logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] r;
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_SHL:  r = (y >= 3'd3) ? '0 : (x << y);
      OP_SHR:  r = (y >= 3'd3) ? '0 : (x >> y);
      OP_CMP:  r = (x == y) ? 3'd0 : ((x > y) ? 3'd1 : 3'd2);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x3-bit register file: two asynchronous read ports, one synchronous write port,
// synchronous active-low clear of every entry.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        ra_addr,
  input  logic [2:0]        rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];

  always_comb begin
    // NOTE: start from the held value so every path assigns mem_d and no latch is inferred.
    mem_d = mem_q;
    if (we) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: this array is cleared on reset on purpose: software relies on r0 reading 0.
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Register-file front end for the 3-bit ALU: accepts one instruction, executes it
// in one cycle, writes rd back and holds the result until downstream takes it.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_rd,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   retired
);

  state_e             state_q,    state_d;
  instr_t             instr_q,    instr_d;
  logic [2:0]         out_rd_q,   out_rd_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [CNT_W-1:0]   retired_q,  retired_d;

  logic [DATA_W-1:0]  ra_data, rb_data, alu_y, alu_result;
  logic               rf_we;

  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (instr_q.ra),
    .rb_addr (instr_q.rb),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .we      (rf_we),
    .wr_addr (instr_q.rd),
    .wr_data (alu_result)
  );

  assign alu_y      = instr_q.imm ? instr_q.rb : rb_data;
  assign alu_result = alu_compute(instr_q.op, ra_data, alu_y);

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    out_rd_d   = out_rd_q;
    out_data_d = out_data_q;
    retired_d  = retired_q;
    rf_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          instr_d = decode_instr(in_instr);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rf_we      = 1'b1;
        out_data_d = alu_result;
        out_rd_d   = instr_q.rd;
        state_d    = ST_WB;
      end
      ST_WB: begin
        if (out_ready) begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      out_rd_q   <= '0;
      out_data_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      out_rd_q   <= out_rd_d;
      out_data_q <= out_data_d;
      retired_q  <= retired_d;
    end
  end

  // Handshake flags are decoded from state alone, never from in_valid or out_ready.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_WB);
  assign out_rd    = out_rd_q;
  assign out_data  = out_data_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus randomized instructions
// compared against an arithmetic reference model of the register file and ALU.
module tb_alu_sequencer;

  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [12:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_rd;
  logic [2:0]        out_data;
  logic [CNT_W-1:0]  retired;

  int total = 0;
  int bad   = 0;
  int model_regs [8];
  int model_retired;

  always #5 clk = ~clk;

  alu_sequencer #(.NREGS(8), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rd    (out_rd),
    .out_data  (out_data),
    .retired   (retired)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_alu(input int op, input int x, input int y);
    case (op)
      0: return (x + y) % 8;
      1: return (x - y + 8) % 8;
      2: return x & y;
      3: return x | y;
      4: return x ^ y;
      5: return (y > 2) ? 0 : (x * (1 << y)) % 8;
      6: return (y > 2) ? 0 : x / (1 << y);
      default: return (x == y) ? 0 : ((x > y) ? 1 : 2);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    model_retired = 0;
  endtask

  // Issues one instruction, optionally stalls the output, and checks every phase.
  task automatic run_instr(input int imm, input int op, input int rd, input int ra,
                           input int rb, input int stall, output int result);
    logic [12:0] w;
    int exp_val;
    w = {1'(imm), 3'(op), 3'(rd), 3'(ra), 3'(rb)};
    exp_val = ref_alu(op, model_regs[ra], (imm != 0) ? rb : model_regs[rb]);
    result = exp_val;

    @(negedge clk);
    check("idle_in_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    in_instr = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = 13'($urandom);

    @(negedge clk);
    check("exec_out_valid", int'(out_valid), 0);
    check("exec_in_ready", int'(in_ready), 0);

    @(posedge clk);
    model_regs[rd] = exp_val;
    @(negedge clk);
    check("wb_out_valid", int'(out_valid), 1);
    check("wb_out_rd", int'(out_rd), rd);
    check("wb_out_data", int'(out_data), exp_val);
    check("wb_in_ready", int'(in_ready), 0);

    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_instr = 13'($urandom);
      @(negedge clk);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_rd", int'(out_rd), rd);
      check("stall_out_data", int'(out_data), exp_val);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_retired", int'(retired), model_retired);
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    model_retired = (model_retired + 1) % (1 << CNT_W);
    @(negedge clk);
    check("done_retired", int'(retired), model_retired);
    check("done_out_valid", int'(out_valid), 0);
    check("done_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    int res;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_rd", int'(out_rd), 0);
    check("rst_retired", int'(retired), 0);
    rst_n = 1'b1;

    // Immediate load and register ops with r1=5, r2=3.
    run_instr(1, 0, 1, 0, 5, 0, res); check("plan_ldi_r1", res, 5);
    check("plan_ldi_retired", int'(retired), 1);
    run_instr(1, 0, 2, 0, 3, 0, res); check("plan_ldi_r2", res, 3);
    run_instr(0, 1, 3, 1, 2, 0, res); check("plan_sub", res, 2);
    run_instr(0, 0, 4, 1, 1, 0, res); check("plan_add_wrap", res, 2);
    run_instr(0, 4, 5, 1, 2, 0, res); check("plan_xor", res, 6);
    run_instr(1, 0, 6, 3, 0, 0, res); check("plan_read_r3", res, 2);
    run_instr(0, 7, 7, 1, 2, 0, res); check("plan_cmp_gt", res, 1);
    run_instr(0, 7, 7, 2, 1, 0, res); check("plan_cmp_lt", res, 2);
    run_instr(0, 7, 7, 1, 1, 0, res); check("plan_cmp_eq", res, 0);
    run_instr(1, 5, 6, 1, 3, 0, res); check("plan_shl3", res, 0);
    run_instr(1, 6, 6, 1, 1, 0, res); check("plan_shr1", res, 2);

    // Backpressure: four cycles of out_ready low in WB.
    run_instr(1, 3, 6, 1, 2, 4, res); check("plan_bp_or", res, 7);

    // Reset during EXEC of add r1,r0,#7 discards the instruction.
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = {1'b1, 3'b000, 3'd1, 3'd0, 3'd7};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_retired", int'(retired), 0);
    @(negedge clk);
    check("midrst_out_valid2", int'(out_valid), 0);
    rst_n = 1'b1;
    model_reset();
    run_instr(1, 0, 2, 1, 0, 0, res); check("midrst_r1_zero", res, 0);

    // Randomized traffic; enough instructions to wrap the retired counter.
    for (int n = 0; n < 300; n++) begin
      run_instr(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), res);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
